// File: rtl/i2s_reg_pkg.sv
// Shared definitions for the I2S transceiver APB register bank:
// register offsets, APB handshake states and STATUS field layout.
package i2s_reg_pkg;

  localparam logic [3:0] OFF_CTRL = 4'h0;
  localparam logic [3:0] OFF_TX   = 4'h4;
  localparam logic [3:0] OFF_RX   = 4'h8;
  localparam logic [3:0] OFF_STAT = 4'hC;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } apb_state_t;

  // STATUS occupancy bits sit directly above the flag field
  localparam int STAT_TX_OCC_OFS = 0;
  localparam int STAT_RX_OCC_OFS = 1;

endpackage

// File: rtl/reg_chan.sv
// One channel of the register bank: CTRL register plus one-word TX/RX
// buffers with occupancy tracking and single-cycle FIFO strobes.
module reg_chan #(
  parameter int                DATA_W   = 32,
  parameter int                CTRL_W   = 15,
  parameter logic [CTRL_W-1:0] CTRL_RST = 15'h06D5
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              wr_ctrl,
  input  logic              wr_tx,
  input  logic              rd_rx,
  input  logic [DATA_W-1:0] wdata,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_wen,
  input  logic              tx_full,
  input  logic [DATA_W-1:0] rx_data,
  output logic              rx_ren,
  input  logic              rx_empty,
  output logic [DATA_W-1:0] rx_reg,
  output logic              tx_occ,
  output logic              rx_occ
);

  logic [CTRL_W-1:0] ctrl_r;
  logic [DATA_W-1:0] tx_data_r;
  logic              tx_occ_r;
  logic              tx_wen_r;
  logic [DATA_W-1:0] rx_reg_r;
  logic              rx_occ_r;
  logic              rx_fetch_r;
  logic              rx_ren_r;

  // CTRL register
  always_ff @(posedge pclk) begin
    if (preset) begin
      ctrl_r <= CTRL_RST;
    end else if (wr_ctrl) begin
      ctrl_r <= wdata[CTRL_W-1:0];
    end
  end

  // TX buffer: load from APB, hand over to the Tx FIFO when it has room
  always_ff @(posedge pclk) begin
    if (preset) begin
      tx_data_r <= {DATA_W{1'b0}};
      tx_occ_r  <= 1'b0;
      tx_wen_r  <= 1'b0;
    end else begin
      tx_wen_r <= 1'b0;
      if (wr_tx) begin
        tx_data_r <= wdata;
        tx_occ_r  <= 1'b1;
      end else if (tx_occ_r && !tx_full) begin
        tx_occ_r <= 1'b0;
        tx_wen_r <= 1'b1;
      end
    end
  end

  // RX buffer: FIFO data is valid the cycle after rx_ren, so capture one cycle later
  always_ff @(posedge pclk) begin
    if (preset) begin
      rx_reg_r   <= {DATA_W{1'b0}};
      rx_occ_r   <= 1'b0;
      rx_fetch_r <= 1'b0;
      rx_ren_r   <= 1'b0;
    end else begin
      rx_ren_r <= 1'b0;
      if (rd_rx) begin
        rx_occ_r <= 1'b0;
      end else if (rx_fetch_r && !rx_ren_r) begin
        rx_reg_r   <= rx_data;
        rx_occ_r   <= 1'b1;
        rx_fetch_r <= 1'b0;
      end else if (!rx_occ_r && !rx_fetch_r && !rx_empty) begin
        rx_ren_r   <= 1'b1;
        rx_fetch_r <= 1'b1;
      end
    end
  end

  assign ctrl    = ctrl_r;
  assign tx_data = tx_data_r;
  assign tx_wen  = tx_wen_r;
  assign rx_reg  = rx_reg_r;
  assign rx_ren  = rx_ren_r;
  assign tx_occ  = tx_occ_r;
  assign rx_occ  = rx_occ_r;

endmodule

// File: rtl/apb_reg_bank.sv
// Multi-channel APB slave register bank for the I2S transceiver: APB
// handshake FSM with wait/timeout, address decode and read mux.
module apb_reg_bank
  import i2s_reg_pkg::*;
#(
  parameter int                NUM_CH        = 2,
  parameter int                DATA_W        = 32,
  parameter int                CTRL_W        = 15,
  parameter int                FLAG_W        = 12,
  parameter int                ADDR_W        = 8,
  parameter int                STALL_ON_BUSY = 1,
  parameter int                TIMEOUT       = 16,
  parameter logic [CTRL_W-1:0] CTRL_RST      = 15'h06D5
) (
  input  logic                     pclk,
  input  logic                     preset,
  input  logic                     psel,
  input  logic                     penable,
  input  logic                     pwrite,
  input  logic [ADDR_W-1:0]        paddr,
  input  logic [DATA_W-1:0]        pwdata,
  output logic [DATA_W-1:0]        prdata,
  output logic                     pready,
  output logic                     pslverr,
  output logic [NUM_CH*CTRL_W-1:0] ctrl_o,
  output logic [NUM_CH*DATA_W-1:0] tx_data,
  output logic [NUM_CH-1:0]        tx_wen,
  input  logic [NUM_CH-1:0]        tx_full,
  input  logic [NUM_CH*DATA_W-1:0] rx_data,
  output logic [NUM_CH-1:0]        rx_ren,
  input  logic [NUM_CH-1:0]        rx_empty,
  input  logic [NUM_CH*FLAG_W-1:0] flags
);

  localparam int CH_W  = ADDR_W - 4;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  apb_state_t        state_r;
  apb_state_t        state_nxt_s;
  logic [CNT_W-1:0]  wait_cnt_r;
  logic              pready_r;
  logic              pslverr_r;
  logic [DATA_W-1:0] prdata_r;

  logic [CH_W-1:0]   ch_s;
  logic [3:0]        off_s;
  logic              ch_hit_s;
  logic              ch_ok_s;
  logic              dec_err_s;
  logic              busy_s;
  logic              perform_s;
  logic              resp_s;
  logic              resp_err_s;
  logic [DATA_W-1:0] rdata_s;

  logic [NUM_CH-1:0] wr_ctrl_s;
  logic [NUM_CH-1:0] wr_tx_s;
  logic [NUM_CH-1:0] rd_rx_s;
  logic [NUM_CH-1:0] tx_occ_v_s;
  logic [NUM_CH-1:0] rx_occ_v_s;
  logic [DATA_W-1:0] rx_reg_v_s [NUM_CH];

  logic [CTRL_W-1:0] sel_ctrl_s;
  logic [FLAG_W-1:0] sel_flags_s;
  logic [DATA_W-1:0] sel_rx_reg_s;
  logic              sel_tx_occ_s;
  logic              sel_rx_occ_s;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign wr_ctrl_s[c] = perform_s && pwrite && (off_s == OFF_CTRL) && (ch_s == CH_W'(c));
    assign wr_tx_s[c]   = perform_s && pwrite && (off_s == OFF_TX) && (ch_s == CH_W'(c));
    assign rd_rx_s[c]   = perform_s && !pwrite && (off_s == OFF_RX) && (ch_s == CH_W'(c));

    reg_chan #(
      .DATA_W   (DATA_W),
      .CTRL_W   (CTRL_W),
      .CTRL_RST (CTRL_RST)
    ) u_chan (
      .pclk     (pclk),
      .preset   (preset),
      .wr_ctrl  (wr_ctrl_s[c]),
      .wr_tx    (wr_tx_s[c]),
      .rd_rx    (rd_rx_s[c]),
      .wdata    (pwdata),
      .ctrl     (ctrl_o[c*CTRL_W +: CTRL_W]),
      .tx_data  (tx_data[c*DATA_W +: DATA_W]),
      .tx_wen   (tx_wen[c]),
      .tx_full  (tx_full[c]),
      .rx_data  (rx_data[c*DATA_W +: DATA_W]),
      .rx_ren   (rx_ren[c]),
      .rx_empty (rx_empty[c]),
      .rx_reg   (rx_reg_v_s[c]),
      .tx_occ   (tx_occ_v_s[c]),
      .rx_occ   (rx_occ_v_s[c])
    );
  end

  // Address decode and one-hot selection of the addressed channel's state
  always_comb begin
    ch_s         = paddr[ADDR_W-1:4];
    off_s        = paddr[3:0];
    ch_hit_s     = 1'b0;
    ch_ok_s      = 1'b0;
    sel_ctrl_s   = {CTRL_W{1'b0}};
    sel_flags_s  = {FLAG_W{1'b0}};
    sel_rx_reg_s = {DATA_W{1'b0}};
    sel_tx_occ_s = 1'b0;
    sel_rx_occ_s = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      ch_hit_s     = (ch_s == CH_W'(c));
      ch_ok_s      = ch_ok_s | ch_hit_s;
      sel_ctrl_s   = sel_ctrl_s | (ctrl_o[c*CTRL_W +: CTRL_W] & {CTRL_W{ch_hit_s}});
      sel_flags_s  = sel_flags_s | (flags[c*FLAG_W +: FLAG_W] & {FLAG_W{ch_hit_s}});
      sel_rx_reg_s = sel_rx_reg_s | (rx_reg_v_s[c] & {DATA_W{ch_hit_s}});
      sel_tx_occ_s = sel_tx_occ_s | (tx_occ_v_s[c] & ch_hit_s);
      sel_rx_occ_s = sel_rx_occ_s | (rx_occ_v_s[c] & ch_hit_s);
    end
    dec_err_s = !ch_ok_s || (paddr[1:0] != 2'b00) ||
                (pwrite && ((off_s == OFF_RX) || (off_s == OFF_STAT))) ||
                (!pwrite && (off_s == OFF_TX));
    busy_s    = pwrite ? ((off_s == OFF_TX) && sel_tx_occ_s)
                       : ((off_s == OFF_RX) && !sel_rx_occ_s);
  end

  // Read data mux
  always_comb begin
    rdata_s = {DATA_W{1'b0}};
    case (off_s)
      OFF_CTRL: rdata_s = DATA_W'(sel_ctrl_s);
      OFF_RX:   rdata_s = sel_rx_reg_s;
      OFF_STAT: begin
        rdata_s[FLAG_W-1:0]                = sel_flags_s;
        rdata_s[FLAG_W + STAT_TX_OCC_OFS]  = sel_tx_occ_s;
        rdata_s[FLAG_W + STAT_RX_OCC_OFS]  = sel_rx_occ_s;
      end
      default:  rdata_s = {DATA_W{1'b0}};
    endcase
  end

  // APB handshake next-state logic; side effects fire only on perform_s
  always_comb begin
    state_nxt_s = state_r;
    resp_s      = 1'b0;
    resp_err_s  = 1'b0;
    perform_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (psel && penable) state_nxt_s = EVAL;
        else                 state_nxt_s = IDLE;
      end
      EVAL: begin
        if (!psel) begin
          state_nxt_s = IDLE;
        end else if (dec_err_s) begin
          state_nxt_s = RESP;
          resp_s      = 1'b1;
          resp_err_s  = 1'b1;
        end else if (busy_s) begin
          if (STALL_ON_BUSY != 0) begin
            state_nxt_s = WAIT;
          end else begin
            state_nxt_s = RESP;
            resp_s      = 1'b1;
            resp_err_s  = 1'b1;
          end
        end else begin
          state_nxt_s = RESP;
          resp_s      = 1'b1;
          perform_s   = 1'b1;
        end
      end
      WAIT: begin
        if (!psel) begin
          state_nxt_s = IDLE;
        end else if (!busy_s && !dec_err_s) begin
          state_nxt_s = RESP;
          resp_s      = 1'b1;
          perform_s   = 1'b1;
        end else if (wait_cnt_r == CNT_W'(TIMEOUT)) begin
          state_nxt_s = RESP;
          resp_s      = 1'b1;
          resp_err_s  = 1'b1;
        end else begin
          state_nxt_s = WAIT;
        end
      end
      RESP:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM state, wait counter and registered APB response
  always_ff @(posedge pclk) begin
    if (preset) begin
      state_r    <= IDLE;
      wait_cnt_r <= {CNT_W{1'b0}};
      pready_r   <= 1'b0;
      pslverr_r  <= 1'b0;
      prdata_r   <= {DATA_W{1'b0}};
    end else begin
      state_r    <= state_nxt_s;
      wait_cnt_r <= ((state_r == WAIT) && (state_nxt_s == WAIT)) ? wait_cnt_r + CNT_W'(1)
                                                                 : {CNT_W{1'b0}};
      pready_r   <= resp_s;
      pslverr_r  <= resp_err_s;
      prdata_r   <= (resp_s && !resp_err_s && !pwrite) ? rdata_s : {DATA_W{1'b0}};
    end
  end

  assign pready  = pready_r;
  assign pslverr = pslverr_r;
  assign prdata  = prdata_r;

endmodule
